// File: rtl/writeback_stage_pkg.sv
// Shared types and constants for the writeback stage: register word/tag types,
// load funct3 encodings and the writeback FSM state enum.
package writeback_stage_pkg;

  localparam int WORD_W = 32;
  localparam int TAG_W  = 5;

  typedef logic [WORD_W-1:0] word_t;
  typedef logic [TAG_W-1:0]  tag_t;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic {
    WB_IDLE      = 1'b0,
    WB_WAIT_LOAD = 1'b1
  } wb_state_t;

endpackage

// File: rtl/writeback_stage_load_extract.sv
// Combinational load data shaping: picks the byte/halfword addressed inside an
// aligned memory word, sign- or zero-extends it and flags misaligned/illegal loads.
module load_extract
  import writeback_stage_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic [1:0] addr,
  input  word_t      rdata,
  output word_t      value,
  output logic       fault
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = rdata[7:0];
    case (addr)
      2'd0:    w_byte = rdata[7:0];
      2'd1:    w_byte = rdata[15:8];
      2'd2:    w_byte = rdata[23:16];
      default: w_byte = rdata[31:24];
    endcase
    w_half = addr[1] ? rdata[31:16] : rdata[15:0];
  end

  always_comb begin
    value = '0;
    fault = 1'b0;
    case (funct3)
      F3_LB:   value = {{24{w_byte[7]}}, w_byte};
      F3_LBU:  value = {24'b0, w_byte};
      F3_LH: begin
        value = {{16{w_half[15]}}, w_half};
        fault = addr[0];
      end
      F3_LHU: begin
        value = {16'b0, w_half};
        fault = addr[0];
      end
      F3_LW: begin
        value = rdata;
        fault = (addr != 2'b00);
      end
      default: fault = 1'b1;
    endcase
  end

endmodule

// File: rtl/writeback_stage.sv
// Final pipeline stage: retires ALU results immediately and parks loads in
// WAIT_LOAD until memory returns data, then writes the register file.
module writeback_stage
  import writeback_stage_pkg::*;
#(
  parameter int INSTRET_WIDTH = 64
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     in_write_rd,
  input  tag_t                     in_rd,
  input  word_t                    in_result,
  input  logic                     in_is_load,
  input  logic [2:0]               in_funct3,
  input  logic                     mem_rvalid,
  input  word_t                    mem_rdata,
  output logic                     write_rd,
  output tag_t                     rd,
  output word_t                    rd_value,
  output logic                     retire,
  output logic                     load_fault,
  output logic [INSTRET_WIDTH-1:0] instret,
  output logic                     dbg_state
);

  // Handshake: an instruction transfers on a rising edge where in_valid and
  // in_ready are both 1; in_ready depends only on state, never on in_valid.

  wb_state_t r_state;
  wb_state_t w_state_next;

  logic       r_load_wr;
  tag_t       r_load_rd;
  logic [2:0] r_load_funct3;
  logic [1:0] r_load_addr;

  logic                     r_write_rd;
  tag_t                     r_rd;
  word_t                    r_rd_value;
  logic                     r_retire;
  logic                     r_load_fault;
  logic [INSTRET_WIDTH-1:0] r_instret;

  logic  w_capture;
  logic  w_retire;
  logic  w_write;
  logic  w_fault;
  tag_t  w_rd;
  word_t w_value;
  word_t w_ext_value;
  logic  w_ext_fault;

  load_extract u_load_extract (
    .funct3 (r_load_funct3),
    .addr   (r_load_addr),
    .rdata  (mem_rdata),
    .value  (w_ext_value),
    .fault  (w_ext_fault)
  );

  always_ff @(posedge clock) begin
    if (reset) r_state <= WB_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_capture    = 1'b0;
    w_retire     = 1'b0;
    w_write      = 1'b0;
    w_fault      = 1'b0;
    w_rd         = r_rd;
    w_value      = r_rd_value;
    case (r_state)
      WB_IDLE: begin
        if (in_valid) begin
          if (in_is_load) begin
            w_capture    = 1'b1;
            w_state_next = WB_WAIT_LOAD;
          end else begin
            w_retire = 1'b1;
            w_write  = in_write_rd && (in_rd != '0);
            w_rd     = in_rd;
            w_value  = in_result;
          end
        end
      end
      WB_WAIT_LOAD: begin
        if (mem_rvalid) begin
          w_state_next = WB_IDLE;
          if (w_ext_fault) begin
            w_fault = 1'b1;
          end else begin
            w_retire = 1'b1;
            w_write  = r_load_wr && (r_load_rd != '0);
            w_rd     = r_load_rd;
            w_value  = w_ext_value;
          end
        end
      end
      default: w_state_next = WB_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_write_rd    <= 1'b0;
      r_rd          <= '0;
      r_rd_value    <= '0;
      r_retire      <= 1'b0;
      r_load_fault  <= 1'b0;
      r_instret     <= '0;
      r_load_wr     <= 1'b0;
      r_load_rd     <= '0;
      r_load_funct3 <= '0;
      r_load_addr   <= '0;
    end else begin
      r_write_rd   <= w_write;
      r_retire     <= w_retire;
      r_load_fault <= w_fault;
      // rd/rd_value only move on a retire so they hold across faults and idles
      if (w_retire) begin
        r_rd       <= w_rd;
        r_rd_value <= w_value;
        r_instret  <= r_instret + INSTRET_WIDTH'(1);
      end
      if (w_capture) begin
        r_load_wr     <= in_write_rd;
        r_load_rd     <= in_rd;
        r_load_funct3 <= in_funct3;
        r_load_addr   <= in_result[1:0];
      end
    end
  end

  assign in_ready   = (r_state == WB_IDLE);
  assign write_rd   = r_write_rd;
  assign rd         = r_rd;
  assign rd_value   = r_rd_value;
  assign retire     = r_retire;
  assign load_fault = r_load_fault;
  assign instret    = r_instret;
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_writeback_stage.sv
// Self-checking bench for writeback_stage: directed scenarios with literal
// expectations plus randomized traffic checked every cycle against a reference model.
module tb_writeback_stage;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_write_rd;
  logic [4:0]  in_rd;
  logic [31:0] in_result;
  logic        in_is_load;
  logic [2:0]  in_funct3;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  logic        in_ready, write_rd, retire, load_fault, dbg_state;
  logic [4:0]  rd;
  logic [31:0] rd_value;
  logic [63:0] instret;

  logic        in_ready4, write_rd4, retire4, load_fault4, dbg_state4;
  logic [4:0]  rd4;
  logic [31:0] rd_value4;
  logic [3:0]  instret4;

  int n_checks = 0;
  int n_errors = 0;
  logic cmp_en = 1'b0;

  always #5 clock = ~clock;

  writeback_stage u_dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_write_rd(in_write_rd), .in_rd(in_rd), .in_result(in_result),
    .in_is_load(in_is_load), .in_funct3(in_funct3), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata), .write_rd(write_rd), .rd(rd), .rd_value(rd_value),
    .retire(retire), .load_fault(load_fault), .instret(instret), .dbg_state(dbg_state)
  );

  writeback_stage #(.INSTRET_WIDTH(4)) u_dut4 (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready4),
    .in_write_rd(in_write_rd), .in_rd(in_rd), .in_result(in_result),
    .in_is_load(in_is_load), .in_funct3(in_funct3), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata), .write_rd(write_rd4), .rd(rd4), .rd_value(rd_value4),
    .retire(retire4), .load_fault(load_fault4), .instret(instret4), .dbg_state(dbg_state4)
  );

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Reference load semantics: size/alignment/extension from the ISA rules.
  task automatic ref_load(input logic [2:0] f3, input logic [1:0] a, input logic [31:0] data,
                          output logic [31:0] val, output logic flt);
    int size;
    logic [31:0] mask;
    logic [31:0] shifted;
    flt = 1'b0;
    size = 0;
    case (f3)
      3'd0, 3'd4: size = 1;
      3'd1, 3'd5: size = 2;
      3'd2:       size = 4;
      default:    flt = 1'b1;
    endcase
    val = 32'h0;
    if (!flt && (int'(a) % size) != 0) flt = 1'b1;
    if (!flt) begin
      shifted = data >> (8 * int'(a));
      mask = (size == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * size)) - 1);
      val = shifted & mask;
      if (f3[2] == 1'b0 && size < 4 && val[8*size-1]) val = val | ~mask;
    end
  endtask

  logic        m_busy = 1'b0;
  logic        m_pwr;
  logic [4:0]  m_prd;
  logic [2:0]  m_pf3;
  logic [1:0]  m_pa;
  logic        m_write = 1'b0, m_retire = 1'b0, m_fault = 1'b0;
  logic [4:0]  m_rd = '0;
  logic [31:0] m_val = '0;
  longint unsigned m_count = 0;

  always @(posedge clock) begin
    logic [31:0] lv;
    logic lf;
    m_write  = 1'b0;
    m_retire = 1'b0;
    m_fault  = 1'b0;
    if (reset) begin
      m_busy  = 1'b0;
      m_rd    = '0;
      m_val   = '0;
      m_count = 0;
    end else if (!m_busy) begin
      if (in_valid && in_is_load) begin
        m_busy = 1'b1;
        m_pwr = in_write_rd;
        m_prd = in_rd;
        m_pf3 = in_funct3;
        m_pa  = in_result[1:0];
      end else if (in_valid) begin
        m_retire = 1'b1;
        m_write  = in_write_rd && in_rd != 0;
        m_rd     = in_rd;
        m_val    = in_result;
        m_count++;
      end
    end else if (mem_rvalid) begin
      m_busy = 1'b0;
      ref_load(m_pf3, m_pa, mem_rdata, lv, lf);
      if (lf) begin
        m_fault = 1'b1;
      end else begin
        m_retire = 1'b1;
        m_write  = m_pwr && m_prd != 0;
        m_rd     = m_prd;
        m_val    = lv;
        m_count++;
      end
    end
  end

  always @(negedge clock) begin
    if (cmp_en) begin
      chk("in_ready",   {63'b0, in_ready},   {63'b0, !m_busy});
      chk("write_rd",   {63'b0, write_rd},   {63'b0, m_write});
      chk("rd",         {59'b0, rd},         {59'b0, m_rd});
      chk("rd_value",   {32'b0, rd_value},   {32'b0, m_val});
      chk("retire",     {63'b0, retire},     {63'b0, m_retire});
      chk("load_fault", {63'b0, load_fault}, {63'b0, m_fault});
      chk("instret",    instret,             m_count);
      chk("instret4",   {60'b0, instret4},   {60'b0, m_count[3:0]});
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic send_nonload(input logic [4:0] r, input logic [31:0] res, input logic wr);
    in_valid = 1'b1; in_is_load = 1'b0; in_rd = r; in_result = res; in_write_rd = wr;
    in_funct3 = 3'($urandom_range(0, 7));
    step();
    in_valid = 1'b0;
  endtask

  task automatic send_load(input logic [2:0] f3, input logic [31:0] addr, input logic [4:0] r);
    in_valid = 1'b1; in_is_load = 1'b1; in_funct3 = f3; in_result = addr; in_rd = r;
    in_write_rd = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  task automatic give_rdata(input logic [31:0] d);
    mem_rvalid = 1'b1; mem_rdata = d;
    step();
    mem_rvalid = 1'b0;
  endtask

  initial begin
    int wcnt;
    reset = 1'b1; in_valid = 1'b0; in_write_rd = 1'b0; in_rd = '0; in_result = '0;
    in_is_load = 1'b0; in_funct3 = '0; mem_rvalid = 1'b0; mem_rdata = '0;
    step();
    cmp_en = 1'b1;
    step();
    chk("reset_instret", instret, 64'd0);
    chk("reset_ready", {63'b0, in_ready}, 64'd1);
    chk("reset_write", {63'b0, write_rd}, 64'd0);
    reset = 1'b0;
    step();

    send_nonload(5'd5, 32'h1234_5678, 1'b1);
    chk("nl_write", {63'b0, write_rd}, 64'd1);
    chk("nl_rd", {59'b0, rd}, 64'd5);
    chk("nl_value", {32'b0, rd_value}, 64'h1234_5678);
    chk("nl_instret", instret, 64'd1);

    send_nonload(5'd0, 32'h0000_DEAD, 1'b1);
    chk("x0_write", {63'b0, write_rd}, 64'd0);
    chk("x0_retire", {63'b0, retire}, 64'd1);
    send_nonload(5'd7, 32'h0000_BEEF, 1'b0);
    chk("nowr_write", {63'b0, write_rd}, 64'd0);
    chk("nowr_retire", {63'b0, retire}, 64'd1);
    chk("nowr_instret", instret, 64'd3);

    send_load(3'b000, 32'h0000_1003, 5'd9);
    chk("lb_ready0", {63'b0, in_ready}, 64'd0);
    step();
    chk("lb_ready1", {63'b0, in_ready}, 64'd0);
    step();
    chk("lb_ready2", {63'b0, in_ready}, 64'd0);
    give_rdata(32'h80FF_0000);
    chk("lb_value", {32'b0, rd_value}, 64'hFFFF_FF80);
    chk("lb_write", {63'b0, write_rd}, 64'd1);
    chk("lb_rd", {59'b0, rd}, 64'd9);

    send_load(3'b100, 32'h0000_1003, 5'd9);
    step();
    step();
    chk("lbu_ready", {63'b0, in_ready}, 64'd0);
    give_rdata(32'h80FF_0000);
    chk("lbu_value", {32'b0, rd_value}, 64'h0000_0080);
    chk("lbu_instret", instret, 64'd5);

    send_load(3'b001, 32'h0000_2001, 5'd10);
    step();
    give_rdata($urandom);
    chk("lh_fault", {63'b0, load_fault}, 64'd1);
    chk("lh_write", {63'b0, write_rd}, 64'd0);
    chk("lh_retire", {63'b0, retire}, 64'd0);
    send_load(3'b011, 32'h0000_2000, 5'd10);
    give_rdata($urandom);
    chk("f3_011_fault", {63'b0, load_fault}, 64'd1);
    chk("f3_011_instret", instret, 64'd5);
    step();
    chk("fault_pulse", {63'b0, load_fault}, 64'd0);

    send_load(3'b010, 32'h0000_0100, 5'd11);
    reset = 1'b1;
    step();
    reset = 1'b0;
    give_rdata(32'hCAFE_F00D);
    chk("abandon_write", {63'b0, write_rd}, 64'd0);
    chk("abandon_ready", {63'b0, in_ready}, 64'd1);
    chk("abandon_instret", instret, 64'd0);

    wcnt = 0;
    in_valid = 1'b1; in_is_load = 1'b0; in_write_rd = 1'b1;
    for (int i = 1; i <= 15; i++) begin
      in_rd = 5'(i); in_result = $urandom;
      step();
      if (i <= 10) wcnt += int'(write_rd);
    end
    chk("b2b_writes", 64'(wcnt), 64'd10);
    chk("instret4_15", {60'b0, instret4}, 64'd15);
    in_rd = 5'd16;
    step();
    in_valid = 1'b0;
    chk("instret4_wrap", {60'b0, instret4}, 64'd0);
    chk("instret_16", instret, 64'd16);

    for (int i = 0; i < 3000; i++) begin
      reset       = ($urandom_range(0, 199) == 0);
      in_valid    = ($urandom_range(0, 2) != 0);
      in_is_load  = ($urandom_range(0, 2) == 0);
      in_funct3   = 3'($urandom_range(0, 7));
      in_result   = $urandom;
      in_rd       = 5'($urandom_range(0, 31));
      in_write_rd = 1'($urandom_range(0, 1));
      mem_rvalid  = 1'($urandom_range(0, 1));
      mem_rdata   = $urandom;
      step();
    end
    reset = 1'b0; in_valid = 1'b0; mem_rvalid = 1'b0;
    step();
    step();
    cmp_en = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/writeback_stage.md
WRITEBACK_STAGE -- requirements
Module: writeback_stage

Interface
REQ-001 SHALL have parameter INSTRET_WIDTH, default 64, giving the retired-instruction counter width.
REQ-002 SHALL use one clock and a synchronous, active-high reset, with ports named clock and reset.
REQ-003 clock  in  1  rising-edge clock for all state.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 in_valid  in  1  stage-6 instruction present.
REQ-006 in_ready  out  1  stage accepts the instruction this cycle.
REQ-007 in_write_rd  in  1  instruction writes a destination register.
REQ-008 in_rd  in  tag  destination register index.
REQ-009 in_result  in  word  ALU result, or the load byte address when in_is_load=1.
REQ-010 in_is_load  in  1  instruction is a load.
REQ-011 in_funct3  in  3  load width/sign encoding.
REQ-012 mem_rvalid  in  1  data-memory read data valid.
REQ-013 mem_rdata  in  word  aligned 32-bit word from data memory.
REQ-014 write_rd  out  1  register-file write strobe.
REQ-015 rd  out  tag  register-file write index.
REQ-016 rd_value  out  word  register-file write data.
REQ-017 retire  out  1  one-cycle pulse per retired instruction.
REQ-018 load_fault  out  1  one-cycle pulse per misaligned or illegal load.
REQ-019 instret  out  INSTRET_WIDTH  retired-instruction count.

Function
REQ-020 SHALL implement FSM states IDLE and WAIT_LOAD; in_ready SHALL be 1 exactly when state=IDLE.
REQ-021 Accept = in_valid && in_ready; with in_valid=0 the FSM SHALL hold and outputs SHALL pulse nothing.
REQ-022 Accepted non-load: on the next cycle, retire=1, write_rd=(in_write_rd && in_rd!=0), rd=in_rd, rd_value=in_result; state stays IDLE.
REQ-023 Accepted load: capture rd, write_rd flag, funct3 and addr[1:0]; go to WAIT_LOAD.
REQ-024 In WAIT_LOAD, mem_rvalid=1 SHALL produce the load result on the next cycle and return to IDLE; in_ready stays 0 during the rvalid cycle.
REQ-025 mem_rvalid SHALL be ignored in IDLE.
REQ-026 Load extraction: LB=000 selects byte addr[1:0], sign-extended; LBU=100 same, zero-extended.
REQ-027 Load extraction: LH=001 selects halfword addr[1], sign-extended; LHU=101 same, zero-extended; LW=010 passes the full word.
REQ-028 Faulting loads are LH/LHU with addr[0]=1, LW with addr[1:0]!=0, and funct3 in {011,110,111}.
REQ-029 A faulting load SHALL raise load_fault=1 for one cycle on the output cycle, with write_rd=0 and retire=0.
REQ-030 write_rd, retire and load_fault SHALL be single-cycle pulses; rd and rd_value SHALL hold their last values between pulses.
REQ-031 instret SHALL increment by 1 on every retire pulse, wrapping from all-ones to 0.
REQ-032 Latency SHALL be 1 cycle from accept (non-load) or from mem_rvalid (load) to write_rd; throughput is 1 non-load per cycle.

Reset
REQ-033 While reset=1, state SHALL be IDLE and write_rd, rd, rd_value, retire, load_fault and instret SHALL be 0; in_ready SHALL be 1 from the first cycle after reset.
REQ-034 Reset in WAIT_LOAD SHALL abandon the load with no write, retire or fault; a later mem_rvalid SHALL be ignored.
REQ-035 Reset SHALL take priority over a simultaneous accept or mem_rvalid.

Structure
REQ-036 Types word and tag, the load funct3 constants and the FSM state enum SHALL live in the shared definitions file.
REQ-037 Byte/halfword selection, extension and fault detection SHALL be a combinational sub-module load_extract (inputs funct3, addr[1:0], rdata; outputs value, fault).

Verification
REQ-038 Non-load: in_rd=5, in_result=0x1234_5678, in_write_rd=1 -> next cycle write_rd=1, rd=5, rd_value=0x1234_5678, instret=1.
REQ-039 Write to x0 / no write: in_rd=0 and in_write_rd=1, then in_write_rd=0 -> write_rd=0 both times, retire=1 both times.
REQ-040 LB with addr=0x...3, 3 cycles later mem_rdata=0x80FF_0000 -> rd_value=0xFFFF_FF80; LBU same -> 0x0000_0080; in_ready=0 throughout.
REQ-041 Faulting loads: LH addr=0x...1, and funct3=011 -> load_fault=1, write_rd=0, retire=0, instret unchanged.
REQ-042 Reset in WAIT_LOAD, then mem_rvalid=1 -> no write, in_ready=1, instret=0.
REQ-043 Back-to-back non-loads for 10 cycles -> 10 consecutive writes; INSTRET_WIDTH=4 preset to 15, one retire -> instret=0.
